// File: rtl/hazard_scoreboard_pkg.sv
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Brief    : Shared encodings and constants for the hazard scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        MDU_OP_NONE = 2'd0,
        MDU_OP_HILO = 2'd1,
        MDU_OP_MUL  = 2'd2,
        MDU_OP_DIV  = 2'd3
    } mdu_op_e;

    localparam logic [2:0] TUSE_NONE = 3'b111;
    localparam logic [2:0] TNEW_ALU  = 3'd1;
    localparam logic [2:0] TNEW_DM   = 3'd2;
    localparam logic [2:0] TNEW_CP0  = 3'd2;
    localparam logic [1:0] EPC_WIN   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_sb_counter.sv
// ============================================================================
// Module   : sb_counter
// Brief    : Saturating down-counter with synchronous clear and parallel load.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sb_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear beats load beats decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : D-stage stall unit built on per-register readiness countdowns,
//            MDU busy timer and EPC write-to-eret window.
//            Optional stall performance counter: HAZARD_SB_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int TW         = 3,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CW         = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [AW-1:0] rs_d,
    input  logic [AW-1:0] rt_d,
    input  logic [TW-1:0] tuse_rs,
    input  logic [TW-1:0] tuse_rt,
    input  logic [AW-1:0] a3_d,
    input  logic [TW-1:0] tnew_d,
    input  logic [1:0]    mdu_op_d,
    input  logic          mtc0_epc_d,
    input  logic          eret_d,
    output logic          pc_en,
    output logic          D_en,
    output logic          E_clr,
    output logic [3:0]    stall_cause,
    output logic [31:0]   stall_cycles
);

    localparam logic [TW-1:0] C_TUSE_NONE = '1;

    logic [TW-1:0] w_sb [NREG];
    logic [CW-1:0] w_mdu_cnt;
    logic [1:0]    w_epc_cnt;
    logic          w_rs_stall;
    logic          w_rt_stall;
    logic          w_mdu_stall;
    logic          w_eret_stall;
    logic          w_stall;
    logic          w_issue;
    logic          w_mdu_ld;
    logic [CW-1:0] w_mdu_ld_val;

    assign w_sb[0] = '0;

    // Entry i holds the cycles remaining until the youngest producer of GPR i forwards.
    for (genvar i = 1; i < NREG; i++) begin : g_sb
        sb_counter #(.W(TW)) u_sb_cnt (
            .clk      (clk),
            .reset    (reset),
            .clr_i    (flush),
            .ld_i     (w_issue && (a3_d == AW'(i))),
            .ld_val_i (tnew_d),
            .cnt_o    (w_sb[i])
        );
    end

    assign w_mdu_ld     = w_issue && ((mdu_op_d == MDU_OP_MUL) || (mdu_op_d == MDU_OP_DIV));
    assign w_mdu_ld_val = (mdu_op_d == MDU_OP_DIV) ? CW'(DIV_CYCLES + 1) : CW'(MUL_CYCLES + 1);

    // A started MDU operation survives a flush, so this timer is never cleared.
    sb_counter #(.W(CW)) u_mdu_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (1'b0),
        .ld_i     (w_mdu_ld),
        .ld_val_i (w_mdu_ld_val),
        .cnt_o    (w_mdu_cnt)
    );

    sb_counter #(.W(2)) u_epc_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (flush),
        .ld_i     (w_issue && mtc0_epc_d),
        .ld_val_i (EPC_WIN),
        .cnt_o    (w_epc_cnt)
    );

    assign w_rs_stall   = (rs_d != '0) && (tuse_rs != C_TUSE_NONE) && (w_sb[rs_d] > tuse_rs);
    assign w_rt_stall   = (rt_d != '0) && (tuse_rt != C_TUSE_NONE) && (w_sb[rt_d] > tuse_rt);
    assign w_mdu_stall  = (mdu_op_d != MDU_OP_NONE) && (w_mdu_cnt != '0);
    assign w_eret_stall = eret_d && (w_epc_cnt != '0);

    assign w_stall = (w_rs_stall || w_rt_stall || w_mdu_stall || w_eret_stall) && !flush;
    assign w_issue = !w_stall && !flush;

    assign pc_en       = !w_stall;
    assign D_en        = !w_stall;
    assign E_clr       = w_stall;
    assign stall_cause = {w_eret_stall, w_mdu_stall, w_rt_stall, w_rs_stall};

`ifdef HAZARD_SB_PERF_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
        end else if (w_stall) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Scoreboard bench; reference model tracks absolute ready times.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NREG = 32;
    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  rs_d = '0, rt_d = '0, a3_d = '0;
    logic [2:0]  tuse_rs = 3'b111, tuse_rt = 3'b111, tnew_d = 3'd1;
    logic [1:0]  mdu_op_d = '0;
    logic        mtc0_epc_d = 1'b0, eret_d = 1'b0;
    logic        pc_en, D_en, E_clr;
    logic [3:0]  stall_cause;
    logic [31:0] stall_cycles;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .flush(flush),
        .rs_d(rs_d), .rt_d(rt_d), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
        .a3_d(a3_d), .tnew_d(tnew_d), .mdu_op_d(mdu_op_d),
        .mtc0_epc_d(mtc0_epc_d), .eret_d(eret_d),
        .pc_en(pc_en), .D_en(D_en), .E_clr(E_clr),
        .stall_cause(stall_cause), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs;
        logic [2:0] tu_rs;
        logic [4:0] rt;
        logic [2:0] tu_rt;
        logic [4:0] a3;
        logic [2:0] tnew;
        logic [1:0] mdu;
        logic       mtc0;
        logic       eret;
    } instr_t;

    typedef struct packed {
        logic        pc_en;
        logic        d_en;
        logic        e_clr;
        logic [3:0]  cause;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   dut_stalls = 0;

    // Reference model: absolute cycle at which each resource becomes ready.
    longint      now = 0;
    longint      ready_at [NREG];
    longint      mdu_free = 0;
    longint      epc_free = 0;
    logic [31:0] perf = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (E_clr === 1'b1) dut_stalls++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("outputs", {32'd0, pc_en, D_en, E_clr, stall_cause, stall_cycles},
                {32'd0, e});
        end
    end

    function automatic instr_t mk(int rs, int trs, int rt, int trt, int a3, int tn,
                                  int mdu, int mtc0, int eret);
        instr_t r;
        r.rs = 5'(rs);  r.tu_rs = 3'(trs);
        r.rt = 5'(rt);  r.tu_rt = 3'(trt);
        r.a3 = 5'(a3);  r.tnew = 3'(tn);
        r.mdu = 2'(mdu); r.mtc0 = 1'(mtc0); r.eret = 1'(eret);
        return r;
    endfunction

    function automatic longint remaining(int r);
        if (r == 0) return 0;
        return (ready_at[r] > now) ? ready_at[r] - now : 0;
    endfunction

    function automatic exp_t model_eval(input instr_t in, input logic fl, output logic st);
        exp_t e;
        e.cause[0] = (in.rs != 0) && (in.tu_rs != TUSE_NONE) && (remaining(int'(in.rs)) > longint'(in.tu_rs));
        e.cause[1] = (in.rt != 0) && (in.tu_rt != TUSE_NONE) && (remaining(int'(in.rt)) > longint'(in.tu_rt));
        e.cause[2] = (in.mdu != 0) && (mdu_free > now);
        e.cause[3] = in.eret && (epc_free > now);
        st = (e.cause != 4'd0) && !fl;
        e.pc_en = !st;
        e.d_en  = !st;
        e.e_clr = st;
`ifdef HAZARD_SB_PERF_EN
        e.cyc = perf;
`else
        e.cyc = '0;
`endif
        return e;
    endfunction

    task automatic model_edge(input instr_t in, input logic fl, input logic st);
        if (st) perf = perf + 32'd1;
        if (fl) begin
            for (int r = 0; r < NREG; r++) ready_at[r] = 0;
            epc_free = 0;
        end else if (!st) begin
            if (in.a3 != 0) ready_at[in.a3] = now + 1 + longint'(in.tnew);
            if (in.mdu == 2'd2) mdu_free = now + 2 + MULC;
            if (in.mdu == 2'd3) mdu_free = now + 2 + DIVC;
            if (in.mtc0) epc_free = now + 1 + longint'(EPC_WIN);
        end
        now++;
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        mdu_free = 0;
        epc_free = 0;
        perf = '0;
    endtask

    task automatic drive(input instr_t in, input logic fl);
        rs_d = in.rs; tuse_rs = in.tu_rs; rt_d = in.rt; tuse_rt = in.tu_rt;
        a3_d = in.a3; tnew_d = in.tnew; mdu_op_d = in.mdu;
        mtc0_epc_d = in.mtc0; eret_d = in.eret; flush = fl;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input instr_t in, input logic fl, output logic issued);
        logic st;
        drive(in, fl);
        exp_q.push_back(model_eval(in, fl, st));
        @(posedge clk);
        model_edge(in, fl, st);
        #1;
        issued = !st && !fl;
    endtask

    task automatic issue(input string name, input instr_t in, input int want_stalls);
        int   s0;
        int   n;
        logic iss;
        s0 = dut_stalls;
        n = 0;
        iss = 1'b0;
        while (!iss && n < 40) begin
            step(in, 1'b0, iss);
            n++;
        end
        if (!iss) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no issue within 40 cycles", name);
        end
        if (want_stalls >= 0) chk(name, 64'(dut_stalls - s0), 64'(want_stalls));
    endtask

    task automatic settle();
        for (int i = 0; i < 4; i++) issue("nop", mk(0, 7, 0, 7, 0, 1, 0, 0, 0), -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t nop;
        instr_t ins;
        logic   iss;
        nop = mk(0, 7, 0, 7, 0, 1, 0, 0, 0);
        model_reset();
        drive(nop, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {32'd0, pc_en, D_en, E_clr, stall_cause, stall_cycles},
            {32'd0, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0});
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Load-use and store-data hazards
        issue("lw8", mk(0, 7, 0, 7, 8, TNEW_DM, 0, 0, 0), 0);
        issue("addu_rs8_tuse0", mk(8, 0, 0, 7, 10, TNEW_ALU, 0, 0, 0), 2);
        settle();
        issue("lw8b", mk(0, 7, 0, 7, 8, TNEW_DM, 0, 0, 0), 0);
        issue("sw_rt8_tuse1", mk(0, 1, 8, 1, 0, 1, 0, 0, 0), 1);
        settle();
        // ALU to branch, and $0 producer
        issue("addu9", mk(0, 7, 0, 7, 9, TNEW_ALU, 0, 0, 0), 0);
        issue("beq_rs9", mk(9, 0, 0, 7, 0, 1, 0, 0, 0), 1);
        issue("prod_r0", mk(0, 7, 0, 7, 0, TNEW_DM, 0, 0, 0), 0);
        issue("cons_r0", mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 0);
        settle();
        // MDU busy windows
        issue("mult", mk(0, 7, 0, 7, 0, 1, 2, 0, 0), 0);
        issue("mflo", mk(0, 7, 0, 7, 11, TNEW_ALU, 1, 0, 0), MULC + 1);
        issue("div", mk(0, 7, 0, 7, 0, 1, 3, 0, 0), 0);
        issue("mfhi", mk(0, 7, 0, 7, 12, TNEW_ALU, 1, 0, 0), DIVC + 1);
        issue("mult2", mk(0, 7, 0, 7, 0, 1, 2, 0, 0), 0);
        issue("nonmdu_a", mk(3, 0, 4, 0, 5, TNEW_ALU, 0, 0, 0), 0);
        issue("nonmdu_b", mk(6, 0, 7, 0, 13, TNEW_ALU, 0, 0, 0), 0);
        issue("mflo_gap2", mk(0, 7, 0, 7, 0, 1, 1, 0, 0), MULC + 1 - 2);
        settle();
        // EPC write to eret
        issue("mtc0", mk(0, 7, 0, 7, 0, 1, 0, 1, 0), 0);
        issue("eret", mk(0, 7, 0, 7, 0, 1, 0, 0, 1), 2);
        issue("mtc0b", mk(0, 7, 0, 7, 0, 1, 0, 1, 0), 0);
        issue("gap", nop, 0);
        issue("eret_gap1", mk(0, 7, 0, 7, 0, 1, 0, 0, 1), 1);
        settle();
`ifdef HAZARD_SB_PERF_EN
        chk("perf_total", 64'(stall_cycles), 64'd28);
`else
        chk("perf_tied0", 64'(stall_cycles), 64'd0);
`endif

        // Flush while a load-use consumer waits
        issue("mult_f", mk(0, 7, 0, 7, 0, 1, 2, 0, 0), 0);
        issue("lw8_f", mk(0, 7, 0, 7, 8, TNEW_DM, 0, 0, 0), 0);
        ins = mk(8, 0, 0, 7, 14, TNEW_ALU, 0, 0, 0);
        step(ins, 1'b0, iss);
        chk("addu8_waits", 64'(iss), 64'd0);
        step(ins, 1'b1, iss);
        issue("addu8_after_flush", ins, 0);
        issue("mflo_after_flush", mk(0, 7, 0, 7, 0, 1, 1, 0, 0), 2);
        settle();

        // Reset asserted in the middle of a stall
        issue("lw8_r", mk(0, 7, 0, 7, 8, TNEW_DM, 0, 0, 0), 0);
        step(ins, 1'b0, iss);
        drive(ins, 1'b0);
        reset = 1'b0;
        exp_q.push_back({1'b1, 1'b1, 1'b0, 4'd0, 32'd0});
        #1;
        chk("reset_mid_stall", {61'd0, pc_en, D_en, E_clr}, {61'd0, 3'b110});
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b1;
        issue("addu8_after_reset", ins, 0);

        // Randomized instruction stream; stalled instructions stay in D
        for (int k = 0; k < 500; k++) begin
            int r;
            int n;
            logic fl;
            r = int'($urandom_range(0, 9));
            ins.rs = 5'($urandom_range(0, 7));
            ins.rt = 5'($urandom_range(0, 7));
            ins.tu_rs = ($urandom_range(0, 4) == 4) ? 3'd7 : 3'($urandom_range(0, 2));
            ins.tu_rt = ($urandom_range(0, 4) == 4) ? 3'd7 : 3'($urandom_range(0, 2));
            ins.a3 = 5'($urandom_range(0, 7));
            ins.tnew = 3'($urandom_range(1, 2));
            ins.mdu = (r < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            ins.mtc0 = ($urandom_range(0, 9) == 0);
            ins.eret = ($urandom_range(0, 9) == 0);
            iss = 1'b0;
            fl = 1'b0;
            n = 0;
            while (!iss && !fl && n < 40) begin
                fl = ($urandom_range(0, 19) == 0);
                step(ins, fl, iss);
                n++;
            end
            if (!iss && !fl) begin
                n_cmp++;
                n_bad++;
                $display("FAIL random_issue: instruction %0d never issued", k);
            end
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
